// File: rtl/syn_echelon_pkg.sv
// Shared definitions for the syndrome-space Gaussian eliminator.
//   - DEF_M / DEF_ROWS : default parameter set (extension degree, row count)
//   - clog2            : ceiling log2 helper used across the codebase (min 1)
//   - state_t          : eliminator FSM state encoding
package syn_echelon_pkg;

    // Default parameter set: m = 83 bits per row, 16 syndrome coordinates.
    localparam int DEF_M    = 83;
    localparam int DEF_ROWS = 16;

    // Ceiling log2, never below 1 so that derived widths stay legal.
    function automatic int clog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return (w < 1) ? 1 : w;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEARCH,
        ST_SWAP,
        ST_ELIM,
        ST_NEXT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/syn_echelon_if.sv
// Load / read / control bundle of the Gaussian eliminator.
//   start, ld_en, ld_addr, ld_data, rd_addr : driven by the controller (master)
//   rd_data, rank, busy, finish             : driven by the eliminator (slave)
interface syn_echelon_if
    import syn_echelon_pkg::*;
#(
    parameter int M    = DEF_M,
    parameter int ROWS = DEF_ROWS
);
    localparam int ROW_W = clog2(ROWS);
    localparam int RK_W  = clog2(ROWS + 1);

    logic             start;
    logic             ld_en;
    logic [ROW_W-1:0] ld_addr;
    logic [M-1:0]     ld_data;
    logic [ROW_W-1:0] rd_addr;
    logic [M-1:0]     rd_data;
    logic [RK_W-1:0]  rank;
    logic             busy;
    logic             finish;

    modport master (
        output start, ld_en, ld_addr, ld_data, rd_addr,
        input  rd_data, rank, busy, finish
    );

    modport slave (
        input  start, ld_en, ld_addr, ld_data, rd_addr,
        output rd_data, rank, busy, finish
    );

endinterface

// File: rtl/syn_echelon_row_xor.sv
// Per-row elimination step: a row that has the current column set and is
// not the pivot row itself gets the pivot row XORed in.
//   row_i    : current row contents
//   pivot    : pivot row contents
//   col      : current column index
//   is_pivot : this instance holds the pivot row
//   row_o    : row contents after the elimination step
module syn_echelon_row_xor
    import syn_echelon_pkg::*;
#(
    parameter int M     = DEF_M,
    parameter int COL_W = clog2(DEF_M)
) (
    input  logic [M-1:0]     row_i,
    input  logic [M-1:0]     pivot,
    input  logic [COL_W-1:0] col,
    input  logic             is_pivot,
    output logic [M-1:0]     row_o
);

    assign row_o = (row_i[col] && !is_pivot) ? (row_i ^ pivot) : row_i;

endmodule

// File: rtl/syn_echelon.sv
// In-place GF(2) Gaussian eliminator: reduces the loaded rows to fully
// reduced row-echelon form (pivots scanned from the MSB column down) and
// reports the rank.
//   clk, rst_b : clock, asynchronous active-low reset
//   bus.start  : one-cycle pulse, starts a reduction when idle
//   bus.ld_*   : row write port, honoured only when idle
//   bus.rd_*   : combinational read of the live row contents
//   bus.rank   : pivot count, valid from finish until the next start
//   bus.busy   : high while the reduction runs
//   bus.finish : one-cycle completion pulse
module syn_echelon
    import syn_echelon_pkg::*;
#(
    parameter int M    = DEF_M,
    parameter int ROWS = DEF_ROWS
) (
    input logic         clk,
    input logic         rst_b,
    syn_echelon_if.slave bus
);

    localparam int ROW_W = clog2(ROWS);
    localparam int RK_W  = clog2(ROWS + 1);
    localparam int COL_W = clog2(M);

    state_t           state, state_nxt;
    logic [M-1:0]     rows      [ROWS];
    logic [M-1:0]     rows_elim [ROWS];
    logic [COL_W-1:0] col;
    logic [RK_W-1:0]  r;          // next pivot slot; equals the rank found so far
    logic [ROW_W-1:0] p;          // search offset below r
    logic [RK_W-1:0]  srch_sum;
    logic [ROW_W-1:0] srch_idx;
    logic [ROW_W-1:0] r_idx;
    logic [M-1:0]     pivot;
    logic             srch_hit;
    logic             srch_last;
    logic             exit_now;
    logic             busy_c;
    logic             finish_c;

    assign srch_sum  = r + RK_W'(p);
    assign srch_idx  = srch_sum[ROW_W-1:0];
    assign r_idx     = r[ROW_W-1:0];
    assign pivot     = rows[r_idx];
    assign srch_hit  = rows[srch_idx][col];
    assign srch_last = (srch_sum == RK_W'(ROWS - 1));
    // Leave once every column is scanned or every row already holds a pivot.
    assign exit_now  = (col == '0) || (r == RK_W'(ROWS));

    for (genvar i = 0; i < ROWS; i++) begin : g_row
        syn_echelon_row_xor #(
            .M     (M),
            .COL_W (COL_W)
        ) u_row_xor (
            .row_i    (rows[i]),
            .pivot    (pivot),
            .col      (col),
            .is_pivot (r == RK_W'(i)),
            .row_o    (rows_elim[i])
        );
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values (the row swap below relies on it).
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        busy_c    = 1'b1;
        finish_c  = 1'b0;
        case (state)
            ST_IDLE: begin
                busy_c = 1'b0;
                if (bus.start) state_nxt = ST_SEARCH;
            end
            ST_SEARCH: begin
                if (srch_hit)       state_nxt = ST_SWAP;
                else if (srch_last) state_nxt = ST_NEXT;
            end
            ST_SWAP: state_nxt = ST_ELIM;
            ST_ELIM: state_nxt = ST_NEXT;
            ST_NEXT: state_nxt = exit_now ? ST_DONE : ST_SEARCH;
            ST_DONE: begin
                busy_c    = 1'b0;
                finish_c  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                busy_c    = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // NOTE: the row store is cleared on reset because an aborted reduction
    // must not leave partial results visible on rd_data.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < ROWS; i++) rows[i] <= '0;
            col <= '0;
            r   <= '0;
            p   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // start wins over a simultaneous write, which is dropped
                    if (bus.start) begin
                        col <= COL_W'(M - 1);
                        r   <= '0;
                        p   <= '0;
                    end else if (bus.ld_en) begin
                        rows[bus.ld_addr] <= bus.ld_data;
                    end
                end
                ST_SEARCH: begin
                    if (!srch_hit && !srch_last) p <= p + 1'b1;
                end
                ST_SWAP: begin
                    // p = 0 writes the same row with its own value
                    rows[r_idx]    <= rows[srch_idx];
                    rows[srch_idx] <= rows[r_idx];
                end
                ST_ELIM: begin
                    for (int i = 0; i < ROWS; i++) rows[i] <= rows_elim[i];
                    r <= r + 1'b1;
                end
                ST_NEXT: begin
                    p <= '0;
                    if (!exit_now) col <= col - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.rd_data = rows[bus.rd_addr];
    assign bus.rank    = r;
    assign bus.busy    = busy_c;
    assign bus.finish  = finish_c;

endmodule

// File: tb/tb_syn_echelon.sv
module tb_syn_echelon;
    import syn_echelon_pkg::*;

    localparam int SM = 8;
    localparam int SR = 4;
    localparam int BM = DEF_M;
    localparam int BR = DEF_ROWS;

    typedef logic [BM-1:0] brow_t;

    typedef struct packed {
        logic [3:0][7:0] din;
        logic [3:0][7:0] dexp;
        logic [2:0]      rk;
        logic [7:0]      lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst_b;
    always #5 clk = ~clk;

    syn_echelon_if #(.M(SM), .ROWS(SR)) s_if ();
    syn_echelon_if #(.M(BM), .ROWS(BR)) b_if ();

    syn_echelon #(.M(SM), .ROWS(SR)) u_small (.clk(clk), .rst_b(rst_b), .bus(s_if.slave));
    syn_echelon #(.M(BM), .ROWS(BR)) u_big   (.clk(clk), .rst_b(rst_b), .bus(b_if.slave));

    int    n_cmp = 0;
    int    n_bad = 0;
    vec_t  tbl [6];
    brow_t b_in  [BR];
    brow_t b_exp [BR];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [3:0][7:0] pack4(input logic [7:0] a0, a1, a2, a3);
        logic [3:0][7:0] v;
        v[0] = a0; v[1] = a1; v[2] = a2; v[3] = a3;
        return v;
    endfunction

    function automatic brow_t rnd_row();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[BM-1:0];
    endfunction

    // ---------------- small instance helpers ----------------
    task automatic s_load(input logic [3:0][7:0] v);
        for (int i = 0; i < SR; i++) begin
            @(negedge clk);
            s_if.ld_en = 1'b1; s_if.ld_addr = 2'(i); s_if.ld_data = v[i];
        end
        @(negedge clk);
        s_if.ld_en = 1'b0;
    endtask

    // Pulses start (optionally with a colliding write) and counts cycles to finish.
    task automatic s_run(input bit collide, output int lat);
        bit busy_ok;
        s_if.start = 1'b1;
        if (collide) begin
            s_if.ld_en = 1'b1; s_if.ld_addr = 2'd0; s_if.ld_data = 8'hFF;
        end
        @(negedge clk);
        s_if.start = 1'b0; s_if.ld_en = 1'b0;
        lat = 1; busy_ok = 1'b1;
        while (!s_if.finish && lat < 200) begin
            busy_ok &= s_if.busy;
            @(negedge clk);
            lat++;
        end
        check("small finish seen", {127'd0, s_if.finish}, 128'd1);
        check("small busy during run", {127'd0, busy_ok}, 128'd1);
        check("small busy at finish", {127'd0, s_if.busy}, 128'd0);
    endtask

    task automatic s_read(input int i, output logic [7:0] d);
        s_if.rd_addr = 2'(i);
        #1;
        d = s_if.rd_data;
    endtask

    // ---------------- big instance helpers ----------------
    task automatic b_load();
        for (int i = 0; i < BR; i++) begin
            @(negedge clk);
            b_if.ld_en = 1'b1; b_if.ld_addr = 4'(i); b_if.ld_data = b_in[i];
        end
        @(negedge clk);
        b_if.ld_en = 1'b0;
    endtask

    task automatic b_run(input bit poke);
        int cyc;
        b_if.start = 1'b1;
        @(negedge clk);
        b_if.start = 1'b0;
        cyc = 1;
        while (!b_if.finish && cyc < 3000) begin
            // stray start and write while busy; both must be ignored
            b_if.start   = poke && (cyc == 5);
            b_if.ld_en   = poke && (cyc == 5);
            b_if.ld_addr = '0;
            b_if.ld_data = '1;
            @(negedge clk);
            cyc++;
        end
        b_if.start = 1'b0; b_if.ld_en = 1'b0;
        check("big finish seen", {127'd0, b_if.finish}, 128'd1);
    endtask

    // Reference RREF: XOR-basis keyed by leading bit, back-substitution from
    // low pivots upward, then rows emitted in descending pivot order.
    task automatic model(output int rk);
        brow_t basis [BM];
        bit    have  [BM];
        brow_t v;
        int    k;
        for (int b = 0; b < BM; b++) begin basis[b] = '0; have[b] = 1'b0; end
        for (int i = 0; i < BR; i++) begin
            v = b_in[i];
            for (int b = BM - 1; b >= 0; b--) begin
                if (v[b]) begin
                    if (have[b]) v ^= basis[b];
                    else begin basis[b] = v; have[b] = 1'b1; break; end
                end
            end
        end
        for (int b = 0; b < BM; b++)
            if (have[b])
                for (int h = b + 1; h < BM; h++)
                    if (have[h] && basis[h][b]) basis[h] ^= basis[b];
        for (int i = 0; i < BR; i++) b_exp[i] = '0;
        k = 0;
        for (int b = BM - 1; b >= 0; b--)
            if (have[b]) begin b_exp[k] = basis[b]; k++; end
        rk = k;
    endtask

    task automatic b_gen(input int mode);
        brow_t gen [10];
        int    nb;
        case (mode)
            0: for (int i = 0; i < BR; i++) b_in[i] = rnd_row();
            1: begin
                nb = $urandom_range(1, 10);
                for (int j = 0; j < nb; j++) gen[j] = rnd_row();
                for (int i = 0; i < BR; i++) begin
                    b_in[i] = '0;
                    for (int j = 0; j < nb; j++) if ($urandom_range(0, 1) == 1) b_in[i] ^= gen[j];
                end
            end
            default:
                for (int i = 0; i < BR; i++) begin
                    b_in[i] = (brow_t'(1) << $urandom_range(0, BM - 1)) | (brow_t'(1) << $urandom_range(0, BM - 1));
                    if ($urandom_range(0, 3) == 0) b_in[i] = '0;
                end
        endcase
    endtask

    task automatic b_compare(input string tag);
        int rk;
        model(rk);
        check({tag, " rank"}, {123'd0, b_if.rank}, 128'(rk));
        for (int i = 0; i < BR; i++) begin
            b_if.rd_addr = 4'(i);
            #1;
            check($sformatf("%s row%0d", tag, i), {45'd0, b_if.rd_data}, {45'd0, b_exp[i]});
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int         lat;
        int         fin_cnt;
        bit         busy_seen;
        logic [7:0] d;

        tbl[0] = '{din: pack4(8'h80, 8'h80, 8'h01, 8'h00), dexp: pack4(8'h80, 8'h01, 8'h00, 8'h00), rk: 3'd2, lat: 8'd34};
        tbl[1] = '{din: pack4(8'h03, 8'h05, 8'h06, 8'h0F), dexp: pack4(8'h09, 8'h05, 8'h03, 8'h00), rk: 3'd3, lat: 8'd38};
        tbl[2] = '{din: pack4(8'h01, 8'h02, 8'h04, 8'h08), dexp: pack4(8'h08, 8'h04, 8'h02, 8'h01), rk: 3'd4, lat: 8'd41};
        tbl[3] = '{din: pack4(8'h80, 8'h40, 8'h20, 8'h10), dexp: pack4(8'h80, 8'h40, 8'h20, 8'h10), rk: 3'd4, lat: 8'd17};
        tbl[4] = '{din: pack4(8'hFF, 8'hFF, 8'hFF, 8'hFF), dexp: pack4(8'hFF, 8'h00, 8'h00, 8'h00), rk: 3'd1, lat: 8'd33};
        tbl[5] = '{din: pack4(8'h00, 8'h00, 8'h00, 8'h81), dexp: pack4(8'h81, 8'h00, 8'h00, 8'h00), rk: 3'd1, lat: 8'd36};

        rst_b = 1'b0;
        s_if.start = 1'b0; s_if.ld_en = 1'b0; s_if.ld_addr = '0; s_if.ld_data = '0; s_if.rd_addr = '0;
        b_if.start = 1'b0; b_if.ld_en = 1'b0; b_if.ld_addr = '0; b_if.ld_data = '0; b_if.rd_addr = '0;
        repeat (3) @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);

        // reset state
        check("reset small rank",   {125'd0, s_if.rank},   128'd0);
        check("reset small busy",   {127'd0, s_if.busy},   128'd0);
        check("reset small finish", {127'd0, s_if.finish}, 128'd0);
        check("reset big rank",     {123'd0, b_if.rank},   128'd0);
        for (int i = 0; i < SR; i++) begin
            s_read(i, d);
            check($sformatf("reset small row%0d", i), {120'd0, d}, 128'd0);
        end

        // table-driven vectors on the 8x4 instance
        for (int t = 0; t < 6; t++) begin
            s_load(tbl[t].din);
            s_run(1'b0, lat);
            check($sformatf("vec%0d latency", t), 128'(lat), {120'd0, tbl[t].lat});
            check($sformatf("vec%0d rank", t), {125'd0, s_if.rank}, {125'd0, tbl[t].rk});
            for (int i = 0; i < SR; i++) begin
                s_read(i, d);
                check($sformatf("vec%0d row%0d", t, i), {120'd0, d}, {120'd0, tbl[t].dexp[i]});
            end
        end

        // all-zero rows, with a write colliding with start (write must drop)
        s_load(pack4(8'h00, 8'h00, 8'h00, 8'h00));
        s_run(1'b1, lat);
        check("zero latency", 128'(lat), 128'd41);
        check("zero rank", {125'd0, s_if.rank}, 128'd0);
        for (int i = 0; i < SR; i++) begin
            s_read(i, d);
            check($sformatf("zero row%0d", i), {120'd0, d}, 128'd0);
        end

        // randomized runs on the default-size instance
        for (int k = 0; k < 6; k++) begin
            b_gen(k % 3);
            b_load();
            b_run(k == 1 || k == 4);
            b_compare($sformatf("rand%0d", k));
        end

        // mid-run reset aborts and clears everything
        b_gen(0);
        b_load();
        b_if.start = 1'b1;
        @(negedge clk);
        b_if.start = 1'b0;
        repeat (30) @(negedge clk);
        rst_b = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
        #1;
        check("abort busy", {127'd0, b_if.busy}, 128'd0);
        check("abort rank", {123'd0, b_if.rank}, 128'd0);
        for (int i = 0; i < BR; i++) begin
            b_if.rd_addr = 4'(i);
            #1;
            check($sformatf("abort row%0d", i), {45'd0, b_if.rd_data}, 128'd0);
        end
        fin_cnt = 0; busy_seen = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if (b_if.finish) fin_cnt++;
            busy_seen |= b_if.busy;
        end
        check("abort no finish", 128'(fin_cnt), 128'd0);
        check("abort stays idle", {127'd0, busy_seen}, 128'd0);

        // a fresh load+start after the abort completes normally
        b_gen(1);
        b_load();
        b_run(1'b0);
        b_compare("post-abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/syn_echelon.md
Name: syn_echelon

Overview:
- In-place GF(2) Gaussian eliminator for the ROLLO decrypt syndrome space.
- Loads the syndrome coordinate rows (each an element of GF(2^M) in the polynomial basis) and reduces them to fully reduced row-echelon form. Reports the rank.
- The downstream support-recovery / S1S2 stage reads the reduced basis rows. Control uses the same start/finish pulse convention as the decrypt top level.

Parameters:
- M, 83, row width in bits (extension degree m).
- ROWS, 16, number of rows held (syndrome coordinates).
- ROW_W, clog2(ROWS), row address width (local, derived).
- RK_W, clog2(ROWS+1), rank width (local, derived).

Ports:
- clk  in  1  rising-edge clock.
- rst_b  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins reduction when idle.
- ld_en  in  1  row write strobe; accepted only when idle.
- ld_addr  in  ROW_W  row index for the write.
- ld_data  in  M  row value to write.
- rd_addr  in  ROW_W  row index for the read.
- rd_data  out  M  combinational read of row[rd_addr].
- rank  out  RK_W  number of pivots found; valid from finish until the next start.
- busy  out  1  high from the cycle after an accepted start through the cycle before finish.
- finish  out  1  one-cycle pulse when reduction is complete.

Behaviour:
Reset
- Asynchronous, active-low, on rst_b.
- All rows clear to 0; rank=0; busy=0; finish=0; FSM returns to IDLE.
- A reset mid-operation aborts the reduction and discards partial results.

Column convention
- Columns are processed from col=M-1 (MSB) down to 0.
- Pivot index r starts at 0.

FSM states
- IDLE
  - ld_en writes row[ld_addr] <= ld_data.
  - start has priority over ld_en in the same cycle, and that write is dropped.
  - On start: col=M-1, r=0, p=0, rank=0, go to SEARCH.
- SEARCH
  - Examines one row per cycle: row[r+p] bit col.
  - Bit set: pivot found, go to SWAP.
  - Bit clear and r+p<ROWS-1: p++.
  - Bit clear and r+p=ROWS-1: column is empty, go to NEXT.
- SWAP
  - One cycle; exchanges row[r] and row[r+p].
  - Still one cycle when p=0, with rows unchanged.
- ELIM
  - One cycle. For every row i != r with row[i][col]=1: row[i] ^= row[r] (full reduction, parallel XOR).
  - Then r++ and rank++, go to NEXT.
- NEXT
  - p=0.
  - If col=0 or r=ROWS: go to DONE. Otherwise col--, go to SEARCH.
- DONE
  - finish=1 for this single cycle, busy=0, go to IDLE.

Arithmetic and width
- rank saturates naturally at ROWS; the r=ROWS exit guarantees no overflow.
- col must not wrap below 0; the exit is taken at col=0.

Boundary conditions
- start while busy: ignored.
- ld_en while busy: ignored.
- rd_data during busy returns the live, partially reduced contents; downstream reads only after finish.
- All-zero input
  - Every column takes ROWS SEARCH cycles plus 1 NEXT.
  - Total latency from start to finish = M*(ROWS+1)+1 cycles.
  - rank=0.
- Full-rank input terminates early, once r=ROWS.

Output invariants after finish
- Rows 0..rank-1 are nonzero with strictly decreasing leading-bit positions.
- Each pivot column is zero in all other rows.
- Rows rank..ROWS-1 are zero.

Decomposition:
- Shared package/define file holds:
  - M and ROWS for the parameter set (ROLLO-I/II/III variants);
  - the FSM state encoding constants;
  - the clog2 helper already shared across the codebase.
- One natural sub-module, syn_echelon_row_xor: the per-row conditional XOR `row_i ^= (row_i[col] & i!=r) ? pivot : 0`, instantiated ROWS times. Everything else stays in the top.

Test Plan:
- (M=8, ROWS=4) Load {0x80,0x80,0x01,0x00}, start -> rows {0x80,0x01,0x00,0x00}; rank=2.
- (M=8, ROWS=4) All rows 0x00, start -> finish exactly 8*5+1=41 cycles after start; rank=0; rows remain 0.
- (M=8, ROWS=4) Load {0x03,0x05,0x06,0x0F} -> rows {0x09,0x05,0x03,0x00}; rank=3. Checks the pivot-column invariant and the r<ROWS path through all columns.
- (M=8, ROWS=4) Load identity reversed {0x01,0x02,0x04,0x08} -> rows {0x08,0x04,0x02,0x01}; rank=4. Exercises the early r=ROWS exit and swaps with p>0.
- Default params: random full-rank and rank-deficient rows versus a software RREF model.
  - Compare rank and all rows.
  - Issue start and ld_en while busy and confirm both are ignored.
- Mid-run rst_b low for 1 cycle -> rows all 0, rank=0, busy=0, and no finish pulse. A subsequent load+start completes correctly.
